vga_fb_writer: RTL and testbench

Frame-buffer write engine that sits directly upstream of the VGA scan-out controller. It accepts pixel and rectangle-fill commands from the CPU-side bus and produces the write-port address, data and enable for the 640x480, 8-bit-index image memory that the scan-out side reads. Rectangle fills are expanded in hardware at one pixel per clock.

---
 rtl/vga_fb_pkg.sv | 32 +++
 rtl/fb_addr_gen.sv | 69 ++++++
 rtl/vga_fb_writer.sv | 155 +++++++++++++++
 tb/tb_vga_fb_writer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// +----------------------------------------------------------------------+
// | vga_fb_pkg : shared constants, opcodes and FSM states for the        |
// |              frame-buffer write engine.                              |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 19;

  localparam logic OP_PIXEL = 1'b0;
  localparam logic OP_FILL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FILL    = 2'd2
  } state_t;

  // y*640 built from two shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [8:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 9) + (yw << 7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_addr_gen.sv
// +----------------------------------------------------------------------+
// | fb_addr_gen : x/y walk counters and row-base register producing the  |
// |               registered write address and a last-pixel flag.        |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module fb_addr_gen import vga_fb_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        x1,
  input  logic [8:0]        y1,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [9:0]        x;
  logic [9:0]        x_start;
  logic [9:0]        x_end;
  logic [8:0]        y;
  logic [8:0]        y_end;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] next_row;
  logic [ADDR_W-1:0] load_base;
  logic              row_end;

  assign row_end   = (x == x_end);
  assign last      = row_end && (y == y_end);
  assign next_row  = row_base + ADDR_W'(H_ACTIVE);
  assign load_base = row_base_of(y0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      x_start  <= '0;
      x_end    <= '0;
      y        <= '0;
      y_end    <= '0;
      row_base <= '0;
      addr     <= '0;
    end else if (load) begin
      x        <= x0;
      x_start  <= x0;
      x_end    <= x1;
      y        <= y0;
      y_end    <= y1;
      row_base <= load_base;
      addr     <= load_base + ADDR_W'(x0);
    end else if (step) begin
      if (row_end) begin
        // Wrap straight to the next row so there is no gap cycle.
        x        <= x_start;
        y        <= y + 9'd1;
        row_base <= next_row;
        addr     <= next_row + ADDR_W'(x_start);
      end else begin
        x        <= x + 10'd1;
        addr     <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_fb_writer.sv
// +----------------------------------------------------------------------+
// | vga_fb_writer : pixel / rectangle-fill write engine for the 640x480  |
// |                 8-bit frame buffer. Option macro: FB_VSYNC_WAIT_EN.  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_fb_writer import vga_fb_pkg::*; (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic              iCMD_OP,
  input  logic [9:0]        iX0,
  input  logic [9:0]        iX1,
  input  logic [8:0]        iY0,
  input  logic [8:0]        iY1,
  input  logic [7:0]        iCOLOR,
  input  logic              iVS,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [7:0]        oWR_DATA,
  output logic              oWR_EN,
  output logic              oBUSY,
  output logic              oERR
);

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       reject;
  logic       clipped;
  logic       load;
  logic       step;
  logic       en_nxt;
  logic       busy_nxt;
  logic       err_nxt;
  logic       pix_last;
  logic       vs_fall;
  logic [9:0] x1_eff;
  logic [8:0] y1_eff;

`ifdef FB_VSYNC_WAIT_EN
  logic vs_r;
  logic vs_d;

  // Two stages: edge is seen the cycle after iVS falls, first write one later.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      vs_r <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      vs_r <= iVS;
      vs_d <= vs_r;
    end
  end
  assign vs_fall = vs_d & ~vs_r;
`else
  logic unused_vs;
  assign unused_vs = iVS;
  assign vs_fall   = 1'b0;
`endif

  assign accept  = iCMD_VALID && oCMD_READY;
  assign reject  = (iCMD_OP == OP_FILL) && ((iX1 < iX0) || (iY1 < iY0));
  assign clipped = (iX0 >= 10'(H_ACTIVE)) || (iY0 >= 9'(V_ACTIVE));

  always_comb begin
    x1_eff = iX0;
    y1_eff = iY0;
    if (iCMD_OP == OP_FILL) begin
      x1_eff = (iX1 > 10'(H_ACTIVE - 1)) ? 10'(H_ACTIVE - 1) : iX1;
      y1_eff = (iY1 > 9'(V_ACTIVE - 1))  ? 9'(V_ACTIVE - 1)  : iY1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    en_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            err_nxt = 1'b1;
          end else if (!clipped) begin
            load     = 1'b1;
            busy_nxt = 1'b1;
`ifdef FB_VSYNC_WAIT_EN
            state_nxt = WAIT_VS;
`else
            state_nxt = FILL;
            en_nxt    = 1'b1;
`endif
          end
        end
      end
      WAIT_VS: begin
        busy_nxt = 1'b1;
        if (vs_fall) begin
          state_nxt = FILL;
          en_nxt    = 1'b1;
        end
      end
      FILL: begin
        if (pix_last) begin
          state_nxt = IDLE;
        end else begin
          step     = 1'b1;
          en_nxt   = 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      oCMD_READY <= 1'b0;
      oWR_EN     <= 1'b0;
      oWR_DATA   <= '0;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      state      <= state_nxt;
      oCMD_READY <= (state_nxt == IDLE);
      oWR_EN     <= en_nxt;
      oBUSY      <= busy_nxt;
      oERR       <= err_nxt;
      if (load) begin
        oWR_DATA <= iCOLOR;
      end
    end
  end

  fb_addr_gen u_addr_gen (
    .clk  (iCLK),
    .rst  (iRST),
    .load (load),
    .step (step),
    .x0   (iX0),
    .y0   (iY0),
    .x1   (x1_eff),
    .y1   (y1_eff),
    .addr (oWR_ADDR),
    .last (pix_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_writer.sv
// +----------------------------------------------------------------------+
// | tb_vga_fb_writer : directed self-checking bench for vga_fb_writer.   |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vga_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [9:0]  x0 = '0;
  logic [9:0]  x1 = '0;
  logic [8:0]  y0 = '0;
  logic [8:0]  y1 = '0;
  logic [7:0]  color = '0;
  logic        vs = 1'b1;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wa[$];
  int wd[$];
  int wc[$];
  int busy_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;

  vga_fb_writer dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iCMD_VALID (cmd_valid),
    .oCMD_READY (cmd_ready),
    .iCMD_OP    (cmd_op),
    .iX0        (x0),
    .iX1        (x1),
    .iY0        (y0),
    .iY1        (y1),
    .iCOLOR     (color),
    .iVS        (vs),
    .oWR_ADDR   (wr_addr),
    .oWR_DATA   (wr_data),
    .oWR_EN     (wr_en),
    .oBUSY      (busy),
    .oERR       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle c is the interval after the posedge that set cyc to c.
  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(int'(wr_data));
      wc.push_back(cyc);
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic op, input int ax0, input int ay0, input int ax1,
                       input int ay1, input int col, output int acc);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_op    = op;
    x0        = 10'(ax0);
    y0        = 9'(ay0);
    x1        = 10'(ax1);
    y1        = 9'(ay1);
    color     = 8'(col);
    cmd_valid = 1'b1;
    acc       = cyc;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((busy || !cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("settle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc;
    int acc2;
    int b;
    int bb;
    int be;

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

`ifdef FB_VSYNC_WAIT_EN
    b = wa.size();
    issue(1'b1, 0, 0, 1, 0, 8'h11, acc);
    repeat (50) @(negedge clk);
    chk("vs_no_write", wa.size() - b, 0);
    chk("vs_busy_wait", int'(busy), 1);
    be = cyc;
    vs = 1'b0;
    settle();
    chk("vs_writes", wa.size() - b, 2);
    if (wa.size() - b == 2) begin
      chk("vs_first_cyc", wc[b], be + 2);
      chk("vs_addr1", wa[b + 1], 1);
    end
`else
    // Single pixel at origin.
    b = wa.size();
    issue(1'b0, 0, 0, 0, 0, 8'h3C, acc);
    @(negedge clk);
    chk("px0_busy_n1", int'(busy), 1);
    chk("px0_ready_n1", int'(cmd_ready), 0);
    @(negedge clk);
    chk("px0_ready_n2", int'(cmd_ready), 1);
    chk("px0_busy_n2", int'(busy), 0);
    settle();
    chk("px0_count", wa.size() - b, 1);
    if (wa.size() - b == 1) begin
      chk("px0_addr", wa[b], 0);
      chk("px0_data", wd[b], 8'h3C);
      chk("px0_cyc", wc[b], acc + 1);
    end

    // Bottom-right corner pixel.
    b = wa.size();
    issue(1'b0, 639, 479, 0, 0, 8'hA5, acc);
    settle();
    chk("pxc_count", wa.size() - b, 1);
    if (wa.size() - b == 1) chk("pxc_addr", wa[b], 307199);

    // 3x2 fill across a row boundary.
    b  = wa.size();
    bb = busy_cnt;
    issue(1'b1, 10, 2, 12, 3, 8'h55, acc);
    settle();
    chk("fill_count", wa.size() - b, 6);
    chk("fill_busy", busy_cnt - bb, 6);
    if (wa.size() - b == 6) begin
      chk("fill_a0", wa[b + 0], 1290);
      chk("fill_a1", wa[b + 1], 1291);
      chk("fill_a2", wa[b + 2], 1292);
      chk("fill_a3", wa[b + 3], 1930);
      chk("fill_a4", wa[b + 4], 1931);
      chk("fill_a5", wa[b + 5], 1932);
      chk("fill_data", wd[b + 5], 8'h55);
      chk("fill_first_cyc", wc[b], acc + 1);
      chk("fill_last_cyc", wc[b + 5], acc + 6);
    end

    // Rejected fill, then a pixel accepted in the very next cycle.
    b  = wa.size();
    be = err_cnt;
    issue(1'b1, 9, 0, 5, 0, 8'h77, acc);
    issue(1'b0, 5, 1, 0, 0, 8'h66, acc2);
    settle();
    chk("rej_err_pulses", err_cnt - be, 1);
    chk("rej_err_cyc", err_cyc, acc + 1);
    chk("rej_next_acc", acc2, acc + 1);
    chk("rej_writes", wa.size() - b, 1);
    if (wa.size() - b == 1) chk("rej_px_addr", wa[b], 645);

    // Clamped fill: 10x10 in the bottom-right corner.
    b = wa.size();
    issue(1'b1, 630, 470, 700, 500, 8'h01, acc);
    settle();
    chk("clamp_count", wa.size() - b, 100);
    if (wa.size() - b == 100) begin
      chk("clamp_first", wa[b], 301430);
      chk("clamp_row2", wa[b + 10], 302070);
      chk("clamp_last", wa[b + 99], 307199);
      chk("clamp_last_cyc", wc[b + 99], acc + 100);
    end

    // Off-screen pixel is dropped silently.
    b  = wa.size();
    be = err_cnt;
    issue(1'b0, 640, 0, 0, 0, 8'h22, acc);
    settle();
    chk("clip_writes", wa.size() - b, 0);
    chk("clip_err", err_cnt - be, 0);

    // Back-to-back: second command accepted in the cycle after the last write.
    b = wa.size();
    issue(1'b1, 0, 0, 1, 0, 8'h10, acc);
    issue(1'b0, 7, 0, 0, 0, 8'h20, acc2);
    settle();
    chk("b2b_acc", acc2, acc + 3);
    chk("b2b_count", wa.size() - b, 3);
    if (wa.size() - b == 3) begin
      chk("b2b_addr", wa[b + 2], 7);
      chk("b2b_cyc", wc[b + 2], acc + 4);
    end

    // Reset during the third write of a 4x4 fill.
    b = wa.size();
    issue(1'b1, 0, 0, 3, 3, 8'h99, acc);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_writes", wa.size() - b, 3);
    if (wa.size() - b == 3) chk("mid_rst_a2", wa[b + 2], 2);

    b = wa.size();
    issue(1'b0, 0, 0, 0, 0, 8'h3C, acc);
    settle();
    chk("post_rst_count", wa.size() - b, 1);
    if (wa.size() - b == 1) begin
      chk("post_rst_addr", wa[b], 0);
      chk("post_rst_data", wd[b], 8'h3C);
      chk("post_rst_cyc", wc[b], acc + 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
